// File: rtl/temp_sb_clk_rst_mgr.sv
// rtl/temp_sb_clk_rst_mgr.sv - PLL lock qualification, sequenced reset release and divided clock enables
module temp_sb_clk_rst_mgr #(
   parameter int NUM_CH      = 2,
   parameter int DIV_WIDTH   = 8,
   parameter int NUM_RST     = 3,
   parameter int LOCK_FILTER = 1024,
   parameter int RST_GAP     = 16,
   parameter int LOSS_CNT_W  = 8
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          PLL_LOCK,
   input  logic [NUM_CH*DIV_WIDTH-1:0]   DIV,
   input  logic                          CLR_LOSS,
   output logic [NUM_RST-1:0]            RST_N_OUT,
   output logic [NUM_CH-1:0]             CLK_EN,
   output logic                          READY,
   output logic                          LOCK_LOST,
   output logic [LOSS_CNT_W-1:0]         LOSS_COUNT
);

   localparam int FW        = $clog2(LOCK_FILTER);
   localparam int REL_TOTAL = NUM_RST * RST_GAP;
   localparam int RW        = $clog2(REL_TOTAL + 1);

   typedef enum logic [2:0] {WAIT_LOCK, FILTER, RELEASE, RUN, LOST} state_t;

   state_t               state, state_nx;
   logic                 lock_m, lock_s;
   logic [FW-1:0]        filt_cnt, filt_nx;
   logic [RW-1:0]        rel_cnt, rel_nx;
   logic [NUM_RST-1:0]   rst_nx;

   // Two-flop synchroniser for the asynchronous CCC lock
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= PLL_LOCK;
         lock_s <= lock_m;
      end
   end

   // FSM state, lock filter counter and release sequence counter
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= WAIT_LOCK;
         filt_cnt <= '0;
         rel_cnt  <= '0;
      end else begin
         state    <= state_nx;
         filt_cnt <= filt_nx;
         rel_cnt  <= rel_nx;
      end
   end

   // Next state; counters clear whenever their state is left or entered
   always_comb begin
      state_nx = state;
      filt_nx  = '0;
      rel_nx   = '0;
      case (state)
         WAIT_LOCK: if (lock_s) state_nx = FILTER;
         FILTER: begin
            if (!lock_s)
               state_nx = WAIT_LOCK;
            else if (filt_cnt == FW'(LOCK_FILTER - 1))
               state_nx = RELEASE;
            else
               filt_nx = filt_cnt + 1'b1;
         end
         RELEASE: begin
            if (!lock_s)
               state_nx = LOST;
            else if (rel_cnt == RW'(REL_TOTAL - 1))
               state_nx = RUN;
            else
               rel_nx = rel_cnt + 1'b1;
         end
         RUN:     if (!lock_s) state_nx = LOST;
         LOST:    state_nx = WAIT_LOCK;
         default: state_nx = WAIT_LOCK;
      endcase
   end

   // Reset k releases k*RST_GAP cycles into RELEASE; outputs are registered from next state
   always_comb begin
      rst_nx = '0;
      for (int k = 0; k < NUM_RST; k++)
         rst_nx[k] = (state_nx == RELEASE && int'(rel_nx) >= k * RST_GAP) || state_nx == RUN;
   end

   // Registered reset and ready outputs
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         RST_N_OUT <= '0;
         READY     <= 1'b0;
      end else begin
         RST_N_OUT <= rst_nx;
         READY     <= (state_nx == RUN);
      end
   end

   // Sticky loss flag and saturating loss count; a loss beats a coincident clear
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         LOCK_LOST  <= 1'b0;
         LOSS_COUNT <= '0;
      end else if (state_nx == LOST) begin
         LOCK_LOST <= 1'b1;
         if (CLR_LOSS)
            LOSS_COUNT <= LOSS_CNT_W'(1);
         else if (LOSS_COUNT != {LOSS_CNT_W{1'b1}})
            LOSS_COUNT <= LOSS_COUNT + 1'b1;
      end else if (CLR_LOSS) begin
         LOCK_LOST  <= 1'b0;
         LOSS_COUNT <= '0;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_WIDTH-1:0] div_i, d_cur, cnt;
      logic                 wrap, en_q;

      assign div_i     = DIV[i*DIV_WIDTH +: DIV_WIDTH];
      assign wrap      = (d_cur <= DIV_WIDTH'(1)) || (cnt == d_cur - 1'b1);
      assign CLK_EN[i] = en_q;

      // Divider: divisor is latched only at a period boundary, counter idles at 0 outside RUN
      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            cnt   <= '0;
            d_cur <= '0;
            en_q  <= 1'b0;
         end else begin
            if (state == RUN && !wrap) begin
               cnt <= cnt + 1'b1;
            end else begin
               cnt   <= '0;
               d_cur <= div_i;
            end
            en_q <= (state_nx == RUN) &&
                    ((state == RUN) ? wrap : (div_i <= DIV_WIDTH'(1)));
         end
      end
   end

endmodule

// File: tb/tb_temp_sb_clk_rst_mgr.sv
// tb/tb_temp_sb_clk_rst_mgr.sv - scoreboard bench for temp_sb_clk_rst_mgr
module tb_temp_sb_clk_rst_mgr;

   localparam int NUM_CH  = 2;
   localparam int DW      = 8;
   localparam int NUM_RST = 3;
   localparam int LF      = 32;
   localparam int GAP     = 4;
   localparam int LCW     = 2;
   localparam int CMAX    = (1 << LCW) - 1;
   localparam int OW      = NUM_RST + NUM_CH + 2 + LCW;

   logic                   CLK = 1'b0;
   logic                   RESET_N = 1'b0;
   logic                   PLL_LOCK = 1'b0;
   logic                   CLR_LOSS = 1'b0;
   logic [NUM_CH*DW-1:0]   DIV = '0;
   logic [NUM_RST-1:0]     RST_N_OUT;
   logic [NUM_CH-1:0]      CLK_EN;
   logic                   READY;
   logic                   LOCK_LOST;
   logic [LCW-1:0]         LOSS_COUNT;

   always #5 CLK = ~CLK;

   temp_sb_clk_rst_mgr #(
      .NUM_CH(NUM_CH), .DIV_WIDTH(DW), .NUM_RST(NUM_RST),
      .LOCK_FILTER(LF), .RST_GAP(GAP), .LOSS_CNT_W(LCW)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .PLL_LOCK(PLL_LOCK), .DIV(DIV), .CLR_LOSS(CLR_LOSS),
      .RST_N_OUT(RST_N_OUT), .CLK_EN(CLK_EN), .READY(READY),
      .LOCK_LOST(LOCK_LOST), .LOSS_COUNT(LOSS_COUNT)
   );

   logic [OW-1:0] exp_q[$];
   event          chk_now;
   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;

   // reference model: lock history, qualified-lock run length, loss bookkeeping
   logic          m_m, m_s;
   int            run;
   bit            after_loss;
   bit            m_lost;
   int            m_cnt;
   int            to_go[NUM_CH];
   logic [NUM_CH*DW-1:0] div_r;

   task automatic step(input logic rn, input logic lk, input logic [NUM_CH*DW-1:0] dv, input logic clr);
      logic ls;
      logic [NUM_RST-1:0] r;
      logic [NUM_CH-1:0]  en;
      logic rdy;
      bit   loss_now;
      int   rel, u, d;
      @(negedge CLK);
      if (RESET_N && !rn) begin
         RESET_N = 1'b0;
         exp_q.push_back('0);
         -> chk_now;
      end
      RESET_N  = rn;
      PLL_LOCK = lk;
      DIV      = dv;
      CLR_LOSS = clr;
      r = '0; en = '0; rdy = 1'b0; loss_now = 0;
      if (!rn) begin
         m_m = 0; m_s = 0; run = 0; after_loss = 0; m_lost = 0; m_cnt = 0;
      end else begin
         ls  = m_s;
         m_s = m_m;
         m_m = lk;
         if (after_loss) begin
            run = 0;
            after_loss = 0;
         end else if (ls) begin
            run++;
         end else begin
            if (run > LF) begin
               loss_now = 1;
               after_loss = 1;
            end
            run = 0;
         end
         if (loss_now) begin
            m_lost = 1;
            m_cnt  = clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
         end else if (clr) begin
            m_lost = 0;
            m_cnt  = 0;
         end
         rel = run - LF - 1;
         if (run > LF)
            for (int k = 0; k < NUM_RST; k++) r[k] = (rel >= k * GAP);
         rdy = (run > LF) && (rel >= NUM_RST * GAP);
         if (rdy) begin
            u = rel - NUM_RST * GAP;
            for (int i = 0; i < NUM_CH; i++) begin
               d = int'(dv[i*DW +: DW]);
               if (u == 0) begin
                  en[i] = (d < 2);
                  to_go[i] = (d < 2) ? 1 : d;
               end else begin
                  to_go[i]--;
                  if (to_go[i] == 0) begin
                     en[i] = 1'b1;
                     to_go[i] = (d < 2) ? 1 : d;
                  end
               end
            end
         end
      end
      exp_q.push_back({r, en, rdy, m_lost, LCW'(m_cnt)});
      cyc++;
   endtask

   task automatic hold(input int n, input logic lk);
      for (int j = 0; j < n; j++) step(1'b1, lk, div_r, 1'b0);
   endtask

   // monitor: compare every presented output against the queued expectation
   initial begin
      logic [OW-1:0] act, ex;
      forever begin
         @(posedge CLK or chk_now);
         #1;
         if (exp_q.size() > 0) begin
            ex  = exp_q.pop_front();
            act = {RST_N_OUT, CLK_EN, READY, LOCK_LOST, LOSS_COUNT};
            n_tests++;
            if (act !== ex) begin
               n_fail++;
               $display("FAIL outputs cyc=%0d actual=%b required=%b (rst_n,clk_en,ready,lost,count)",
                        cyc, act, ex);
            end
         end
      end
   end

   initial begin
      int hl, ll;
      logic lk;
      m_m = 0; m_s = 0; run = 0; after_loss = 0; m_lost = 0; m_cnt = 0;
      for (int i = 0; i < NUM_CH; i++) to_go[i] = 0;
      div_r = {8'd3, 8'd0};

      // reset state
      for (int j = 0; j < 3; j++) step(1'b0, 1'b0, div_r, 1'b0);

      // bring-up, then a mid-period divisor change on channel 1
      hold(3 + LF + NUM_RST * GAP + 4, 1'b1);
      div_r[DW +: DW] = 8'd5;
      hold(24, 1'b1);

      // loss in RUN
      hold(6, 1'b0);

      // one-cycle glitch in the middle of filtering, then full bring-up
      hold(3 + LF / 2, 1'b1);
      hold(1, 1'b0);
      hold(3 + LF + NUM_RST * GAP + 10, 1'b1);

      // clear, five losses to saturate, then a loss coincident with a clear
      step(1'b1, 1'b1, div_r, 1'b1);
      for (int j = 0; j < 6; j++) begin
         hold(LF + NUM_RST * GAP + 8, 1'b1);
         if (j == 5) begin
            step(1'b1, 1'b0, div_r, 1'b0);
            step(1'b1, 1'b0, div_r, 1'b0);
            step(1'b1, 1'b0, div_r, 1'b1);
            hold(3, 1'b0);
         end else begin
            hold(5, 1'b0);
         end
      end

      // asynchronous reset in the middle of RELEASE
      hold(3 + LF + 5, 1'b1);
      step(1'b0, 1'b1, div_r, 1'b0);
      step(1'b0, 1'b1, div_r, 1'b0);
      hold(3 + LF + NUM_RST * GAP + 10, 1'b1);

      // randomized lock segments, divisor changes, clears and rare resets
      lk = 1'b0;
      hl = 0;
      ll = 0;
      for (int c = 0; c < 3000; c++) begin
         if (lk && hl == 0) begin
            lk = 1'b0;
            ll = $urandom_range(1, 4);
         end else if (!lk && ll == 0) begin
            lk = 1'b1;
            hl = $urandom_range(1, LF + NUM_RST * GAP + 40);
         end
         if (lk) hl--; else ll--;
         for (int i = 0; i < NUM_CH; i++)
            if ($urandom_range(0, 15) == 0) div_r[i*DW +: DW] = DW'($urandom_range(0, 6));
         step(($urandom_range(0, 999) != 0), lk, div_r, ($urandom_range(0, 40) == 0));
      end

      repeat (3) @(posedge CLK);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/temp_sb_clk_rst_mgr.md
# temp_sb_clk_rst_mgr

Parametrised clock/reset manager that sits directly behind the fabric CCC in the TEMP_sb subsystem, clocked by the CCC global output (GL0). It qualifies the asynchronous PLL LOCK with a synchroniser and a stability filter, then releases NUM_RST domain resets in a timed sequence. Once released, it generates NUM_CH independently divided clock-enable strobes and tracks lock-loss events with a sticky flag and a saturating counter. It replaces ad-hoc "LOCK as reset" wiring with a deterministic bring-up and lock-loss recovery sequence.

## Interface
- NUM_CH, 2, number of clock-enable channels (≥1)
- DIV_WIDTH, 8, width of each channel divisor
- NUM_RST, 3, number of sequenced reset outputs (≥1)
- LOCK_FILTER, 1024, consecutive synchronised-lock cycles required before release (≥2)
- RST_GAP, 16, cycles between successive reset releases (≥1)
- LOSS_CNT_W, 8, width of lock-loss counter

Ports:
- CLK  in  1  GL0 global clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- PLL_LOCK  in  1  CCC LOCK, asynchronous to CLK
- DIV  in  NUM_CH*DIV_WIDTH  per-channel divisor, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
- CLR_LOSS  in  1  synchronous clear of LOCK_LOST and LOSS_COUNT
- RST_N_OUT  out  NUM_RST  sequenced active-low domain resets
- CLK_EN  out  NUM_CH  per-channel one-cycle enable strobes
- READY  out  1  high when all resets released and enables running
- LOCK_LOST  out  1  sticky lock-loss flag
- LOSS_COUNT  out  LOSS_CNT_W  saturating lock-loss event count

## Operation
- PLL_LOCK passes through a 2-flop synchroniser to give lock_s. Only lock_s is used internally.
- All outputs are registered. Reset values: RST_N_OUT=0, CLK_EN=0, READY=0, LOCK_LOST=0, LOSS_COUNT=0, FSM=WAIT_LOCK.
- Asserting RESET_N low at any time forces the reset values immediately, including during RELEASE or RUN.

FSM:
- WAIT_LOCK: all resets asserted, CLK_EN=0. lock_s=1 → FILTER with filter counter cleared.
- FILTER: the filter counter increments on every cycle lock_s=1. lock_s=0 → WAIT_LOCK (counter cleared, not counted as a loss). When the counter reaches LOCK_FILTER-1 → RELEASE.
- RELEASE: RST_N_OUT[k] rises k*RST_GAP cycles after RELEASE entry, k=0..NUM_RST-1, and stays high. RST_GAP cycles after RST_N_OUT[NUM_RST-1] rises → RUN. lock_s=0 → LOST.
- RUN: READY=1, enables active. lock_s=0 → LOST.
- LOST: lasts exactly one cycle. All RST_N_OUT, CLK_EN and READY are 0. LOCK_LOST←1; LOSS_COUNT increments, saturating at 2^LOSS_CNT_W-1. Next state WAIT_LOCK, so the full filter and sequence repeat.

Clock enables (per channel i, with d = DIV slice):
- The counter is held at 0 outside RUN.
- d∈{0,1}: CLK_EN[i]=1 on every RUN cycle.
- d≥2: the counter runs 0..d-1, and CLK_EN[i]=1 on the cycle the counter equals d-1. The first strobe occurs d cycles after READY rises; the period is d.
- d is re-sampled only when the counter wraps. A mid-period DIV change takes effect from the next period.

CLR_LOSS:
- Clears LOCK_LOST and LOSS_COUNT on the next edge.
- If it coincides with a LOST cycle, the loss wins: LOCK_LOST=1 and LOSS_COUNT=1.

## Timing
- PLL_LOCK rise to FILTER entry: 3 edges (2 sync + 1 FSM).
- FILTER entry to RST_N_OUT[0] high: LOCK_FILTER cycles, with lock held steady.
- RST_N_OUT[0] to READY: NUM_RST*RST_GAP cycles.
- PLL_LOCK fall (from RELEASE or RUN) to all outputs low: at most 3 edges, with no intermediate glitch high.
- A lock glitch shorter than 1 cycle may be missed. Any glitch sampled low in FILTER restarts filtering.

## Test plan
- Reset, then PLL_LOCK=1 at cycle 0 (defaults) → RST_N_OUT[0] high at cycle 3+1024, [1] at +16, [2] at +32; READY at +48.
- PLL_LOCK low for 1 sampled cycle at filter count 500 → returns to WAIT_LOCK; LOSS_COUNT stays 0; release timing restarts from the next rise.
- In RUN with DIV={8'd3, 8'd0} → CLK_EN[0] constantly 1; CLK_EN[1] pulses every 3 cycles, first pulse 3 cycles after READY; change DIV[1] to 5 mid-period → period 3 completes, then period 5.
- Drop PLL_LOCK in RUN → all outputs 0 within 3 edges; LOCK_LOST=1, LOSS_COUNT=1; relock → full sequence repeats.
- LOSS_CNT_W=2 with 5 loss events → LOSS_COUNT saturates at 3; CLR_LOSS pulsed on the same cycle as a loss → LOSS_COUNT=1, LOCK_LOST=1.
- RESET_N asserted midway through RELEASE → all outputs 0 asynchronously; after deassert the FSM is in WAIT_LOCK and LOSS_COUNT=0.
